// File: rtl/flash_spi_responder_if.sv
// SPI pins and byte-fetch handshake shared between the flash responder
// (slave side) and whatever plays the SPI master / backing memory.
interface flash_spi_responder_if;
  logic        spi_cs;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_miso;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  modport slave (
    input  spi_cs, spi_sclk, spi_mosi, mem_ack, mem_rdata,
    output spi_miso, mem_req, mem_addr
  );

  modport master (
    output spi_cs, spi_sclk, spi_mosi, mem_ack, mem_rdata,
    input  spi_miso, mem_req, mem_addr
  );
endinterface

// File: rtl/flash_spi_responder.sv
// SPI-flash read responder: decodes cmd 0x03 + 24-bit address, streams bytes
// from a req/ack byte memory out on MISO, one fetch kept in flight ahead.
module flash_spi_responder #(
  parameter int CLK_PER_HALF_SCLK = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  flash_spi_responder_if.slave        bus,
  output logic                        busy,
  output logic [7:0]                  last_cmd,
  output logic                        underrun
);

  if (CLK_PER_HALF_SCLK < 8) begin : g_param_check
    $error("CLK_PER_HALF_SCLK must be at least 8");
  end

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_e;

  logic cs_m_q, cs_s_q, cs_p_q;
  logic sclk_m_q, sclk_s_q, sclk_p_q;
  logic mosi_m_q, mosi_s_q;

  state_e      state_q, state_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  cmd_sh_q, cmd_sh_d;
  logic [23:0] addr_q, addr_d;
  logic [7:0]  data_sh_q, data_sh_d;
  logic        miso_q, miso_d;
  logic        req_q, req_d;
  logic [23:0] mem_addr_q, mem_addr_d;
  logic        pend_q, pend_d;
  logic        discard_q, discard_d;
  logic [7:0]  buf_q, buf_d;
  logic        buf_valid_q, buf_valid_d;
  logic [7:0]  last_cmd_q, last_cmd_d;
  logic        underrun_q, underrun_d;

  logic        rise, fall, cs_fall, abort, ack;
  logic        want_fetch;
  logic [23:0] fetch_addr;
  logic [7:0]  cmd_next;
  logic [23:0] addr_next;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cs_m_q   <= 1'b1;
      cs_s_q   <= 1'b1;
      cs_p_q   <= 1'b1;
      sclk_m_q <= 1'b0;
      sclk_s_q <= 1'b0;
      sclk_p_q <= 1'b0;
      mosi_m_q <= 1'b0;
      mosi_s_q <= 1'b0;
    end else begin
      cs_m_q   <= bus.spi_cs;
      cs_s_q   <= cs_m_q;
      cs_p_q   <= cs_s_q;
      sclk_m_q <= bus.spi_sclk;
      sclk_s_q <= sclk_m_q;
      sclk_p_q <= sclk_s_q;
      mosi_m_q <= bus.spi_mosi;
      mosi_s_q <= mosi_m_q;
    end
  end

  assign rise      = sclk_s_q & ~sclk_p_q;
  assign fall      = ~sclk_s_q & sclk_p_q;
  assign cs_fall   = ~cs_s_q & cs_p_q;
  assign abort     = cs_s_q & (state_q != IDLE);
  assign ack       = req_q & bus.mem_ack;
  assign cmd_next  = {cmd_sh_q[6:0], mosi_s_q};
  assign addr_next = {addr_q[22:0], mosi_s_q};

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    cmd_sh_d    = cmd_sh_q;
    addr_d      = addr_q;
    data_sh_d   = data_sh_q;
    miso_d      = miso_q;
    req_d       = req_q;
    mem_addr_d  = mem_addr_q;
    pend_d      = pend_q;
    discard_d   = discard_q;
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
    last_cmd_d  = last_cmd_q;
    underrun_d  = underrun_q;
    want_fetch  = 1'b0;
    fetch_addr  = addr_q;

    // A fetch orphaned by an abort still completes, but its byte is dropped.
    if (ack) begin
      req_d = 1'b0;
      if (discard_q || abort) begin
        discard_d = 1'b0;
      end else begin
        buf_d       = bus.mem_rdata;
        buf_valid_d = 1'b1;
      end
    end

    if (abort) begin
      state_d     = IDLE;
      miso_d      = 1'b1;
      bit_cnt_d   = 5'd0;
      pend_d      = 1'b0;
      buf_valid_d = 1'b0;
      if (req_q && !bus.mem_ack) discard_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          miso_d = 1'b1;
          if (cs_fall) begin
            state_d     = CMD;
            bit_cnt_d   = 5'd0;
            buf_valid_d = 1'b0;
          end
        end
        CMD: begin
          miso_d = 1'b1;
          if (rise) begin
            cmd_sh_d  = cmd_next;
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              last_cmd_d = cmd_next;
              bit_cnt_d  = 5'd0;
              state_d    = (cmd_next == 8'h03) ? ADDR : IGNORE;
            end
          end
        end
        ADDR: begin
          miso_d = 1'b1;
          if (rise) begin
            addr_d    = addr_next;
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd23) begin
              bit_cnt_d  = 5'd0;
              state_d    = DATA;
              want_fetch = 1'b1;
              fetch_addr = addr_next;
            end
          end
        end
        DATA: begin
          if (fall) begin
            bit_cnt_d = {2'b00, bit_cnt_q[2:0] + 3'd1};
            if (bit_cnt_q[2:0] == 3'd0) begin
              // On a starved boundary the fetch stays outstanding and feeds the next byte.
              if (buf_valid_q) begin
                data_sh_d   = buf_q;
                miso_d      = buf_q[7];
                buf_valid_d = 1'b0;
                addr_d      = addr_q + 24'd1;
                want_fetch  = 1'b1;
                fetch_addr  = addr_q + 24'd1;
              end else begin
                data_sh_d  = 8'hFF;
                miso_d     = 1'b1;
                underrun_d = 1'b1;
              end
            end else begin
              data_sh_d = {data_sh_q[6:0], 1'b1};
              miso_d    = data_sh_q[6];
            end
          end
        end
        IGNORE: begin
          miso_d = 1'b1;
        end
        default: begin
          state_d = IDLE;
          miso_d  = 1'b1;
        end
      endcase
    end

    // New requests wait for the previous one to retire, so at most one is in flight.
    if (want_fetch) begin
      if (!req_q) begin
        req_d      = 1'b1;
        mem_addr_d = fetch_addr;
      end else begin
        pend_d = 1'b1;
      end
    end else if (pend_q && !req_q) begin
      req_d      = 1'b1;
      pend_d     = 1'b0;
      mem_addr_d = addr_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 5'd0;
      cmd_sh_q    <= 8'h00;
      addr_q      <= 24'h000000;
      data_sh_q   <= 8'hFF;
      miso_q      <= 1'b1;
      req_q       <= 1'b0;
      mem_addr_q  <= 24'h000000;
      pend_q      <= 1'b0;
      discard_q   <= 1'b0;
      buf_q       <= 8'h00;
      buf_valid_q <= 1'b0;
      last_cmd_q  <= 8'h00;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      cmd_sh_q    <= cmd_sh_d;
      addr_q      <= addr_d;
      data_sh_q   <= data_sh_d;
      miso_q      <= miso_d;
      req_q       <= req_d;
      mem_addr_q  <= mem_addr_d;
      pend_q      <= pend_d;
      discard_q   <= discard_d;
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
      last_cmd_q  <= last_cmd_d;
      underrun_q  <= underrun_d;
    end
  end

  assign bus.spi_miso = miso_q;
  assign bus.mem_req  = req_q;
  assign bus.mem_addr = mem_addr_q;
  assign busy         = ~cs_s_q;
  assign last_cmd     = last_cmd_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_flash_spi_responder.sv
// Directed bench for flash_spi_responder: SPI master + delayed-ack memory model,
// with MISO bytes and fetch addresses checked against scoreboard queues.
module tb_flash_spi_responder;

  localparam int HALF = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       busy;
  logic [7:0] last_cmd;
  logic       underrun;

  flash_spi_responder_if bus ();

  flash_spi_responder #(.CLK_PER_HALF_SCLK(HALF)) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus.slave),
    .busy     (busy),
    .last_cmd (last_cmd),
    .underrun (underrun)
  );

  always #5 clock = ~clock;

  int          nCompared   = 0;
  int          nMismatched = 0;
  logic [7:0]  expByteQ[$];
  logic [23:0] expAddrQ[$];
  logic [23:0] obsAddrQ[$];
  int          ackDelay = 1;
  int          ackWait  = 0;
  logic        reqSeen  = 1'b0;

  // Mixing in address bits 19:16 keeps 0xFFFFFF distinguishable from idle-high MISO.
  function automatic logic [7:0] memByte(input logic [23:0] a);
    return a[7:0] ^ {4'h0, a[19:16]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 8'h00;
      ackWait       = 0;
      ackDelay      = 1;
      reqSeen       = 1'b0;
    end else begin
      if (bus.mem_req && !reqSeen) obsAddrQ.push_back(bus.mem_addr);
      reqSeen = bus.mem_req;
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
      end else if (bus.mem_req) begin
        if (ackWait >= ackDelay) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = memByte(bus.mem_addr);
          ackWait       = 0;
          ackDelay      = 1;
        end else begin
          ackWait++;
        end
      end
    end
  end

  task automatic spiBits(input logic [7:0] tx, input int nBits, input bit endCs, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 8 - nBits; i--) begin
      bus.spi_mosi = tx[i];
      repeat (HALF) @(negedge clock);
      bus.spi_sclk = 1'b1;
      rx[i] = bus.spi_miso;
      repeat (HALF) @(negedge clock);
      bus.spi_sclk = 1'b0;
      if (endCs && i == 0) bus.spi_cs = 1'b1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] cmd, input bit withAddr, input logic [23:0] addr, input int nData);
    logic [7:0] rx;
    logic [7:0] exp;
    @(negedge clock);
    bus.spi_cs = 1'b0;
    repeat (HALF) @(negedge clock);
    checkOutput("busy_active", 32'(busy), 32'd1);
    spiBits(cmd, 8, 1'b0, rx);
    checkOutput("miso_cmd_phase", 32'(rx), 32'hFF);
    if (withAddr) begin
      spiBits(addr[23:16], 8, 1'b0, rx);
      spiBits(addr[15:8], 8, 1'b0, rx);
      spiBits(addr[7:0], 8, nData == 0, rx);
      checkOutput("miso_addr_phase", 32'(rx), 32'hFF);
    end
    for (int b = 0; b < nData; b++) begin
      spiBits(8'h00, 8, b == nData - 1, rx);
      if (expByteQ.size() == 0) begin
        nCompared++;
        nMismatched++;
        $error("[TB] FAIL scoreboard_empty observed=%0h expected=<none>", rx);
      end else begin
        exp = expByteQ.pop_front();
        checkOutput($sformatf("miso_byte%0d", b), 32'(rx), 32'(exp));
      end
    end
    bus.spi_cs = 1'b1;
    repeat (HALF) @(negedge clock);
    checkOutput("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic checkFetches(input string tag);
    checkOutput({tag, "_fetch_count"}, 32'(obsAddrQ.size()), 32'(expAddrQ.size()));
    for (int i = 0; i < expAddrQ.size() && i < obsAddrQ.size(); i++)
      checkOutput($sformatf("%s_fetch%0d", tag, i), 32'(obsAddrQ[i]), 32'(expAddrQ[i]));
    obsAddrQ.delete();
    expAddrQ.delete();
  endtask

  initial begin
    logic [7:0] rx;
    bus.spi_cs   = 1'b1;
    bus.spi_sclk = 1'b0;
    bus.spi_mosi = 1'b0;
    repeat (4) @(negedge clock);
    checkOutput("rst_miso", 32'(bus.spi_miso), 32'd1);
    checkOutput("rst_req", 32'(bus.mem_req), 32'd0);
    checkOutput("rst_addr", 32'(bus.mem_addr), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_last_cmd", 32'(last_cmd), 32'd0);
    checkOutput("rst_underrun", 32'(underrun), 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    $display("[TB] plain read at 0x100000");
    for (int i = 0; i < 4; i++) expByteQ.push_back(memByte(24'h100000 + 24'(i)));
    for (int i = 0; i < 5; i++) expAddrQ.push_back(24'h100000 + 24'(i));
    applyStimulus(8'h03, 1'b1, 24'h100000, 4);
    checkFetches("read");
    checkOutput("read_underrun", 32'(underrun), 32'd0);
    checkOutput("read_last_cmd", 32'(last_cmd), 32'h03);

    $display("[TB] address wrap at 0xFFFFFF");
    expByteQ.push_back(memByte(24'hFFFFFF));
    expByteQ.push_back(memByte(24'h000000));
    expAddrQ.push_back(24'hFFFFFF);
    expAddrQ.push_back(24'h000000);
    expAddrQ.push_back(24'h000001);
    applyStimulus(8'h03, 1'b1, 24'hFFFFFF, 2);
    checkFetches("wrap");
    checkOutput("wrap_underrun", 32'(underrun), 32'd0);

    $display("[TB] slow first fetch");
    ackDelay = 40;
    expByteQ.push_back(8'hFF);
    expByteQ.push_back(memByte(24'h000020));
    expAddrQ.push_back(24'h000020);
    expAddrQ.push_back(24'h000021);
    applyStimulus(8'h03, 1'b1, 24'h000020, 2);
    checkFetches("urun");
    checkOutput("urun_flag", 32'(underrun), 32'd1);

    $display("[TB] wake command is ignored");
    expByteQ.push_back(8'hFF);
    expByteQ.push_back(8'hFF);
    applyStimulus(8'hAB, 1'b0, 24'h000000, 2);
    checkFetches("wake");
    checkOutput("wake_last_cmd", 32'(last_cmd), 32'hAB);
    checkOutput("urun_sticky", 32'(underrun), 32'd1);

    reset = 1'b1;
    repeat (2) @(negedge clock);
    checkOutput("urun_cleared", 32'(underrun), 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    $display("[TB] abort mid-address then full read");
    bus.spi_cs = 1'b0;
    repeat (HALF) @(negedge clock);
    spiBits(8'h03, 8, 1'b0, rx);
    spiBits(8'h00, 8, 1'b0, rx);
    spiBits(8'h00, 4, 1'b0, rx);
    repeat (HALF) @(negedge clock);
    bus.spi_cs = 1'b1;
    repeat (2 * HALF) @(negedge clock);
    checkFetches("abort");
    expByteQ.push_back(memByte(24'h000010));
    expByteQ.push_back(memByte(24'h000011));
    for (int i = 0; i < 3; i++) expAddrQ.push_back(24'h000010 + 24'(i));
    applyStimulus(8'h03, 1'b1, 24'h000010, 2);
    checkFetches("after_abort");

    $display("[TB] reset while a fetch is outstanding");
    ackDelay = 200;
    bus.spi_cs = 1'b0;
    repeat (HALF) @(negedge clock);
    spiBits(8'h03, 8, 1'b0, rx);
    spiBits(8'h00, 8, 1'b0, rx);
    spiBits(8'h00, 8, 1'b0, rx);
    spiBits(8'h40, 8, 1'b0, rx);
    repeat (6) @(negedge clock);
    checkOutput("req_before_reset", 32'(bus.mem_req), 32'd1);
    reset = 1'b1;
    bus.spi_cs = 1'b1;
    bus.spi_sclk = 1'b0;
    @(negedge clock);
    checkOutput("mid_rst_req", 32'(bus.mem_req), 32'd0);
    checkOutput("mid_rst_miso", 32'(bus.spi_miso), 32'd1);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    obsAddrQ.delete();
    repeat (4) @(negedge clock);
    expByteQ.push_back(memByte(24'h000050));
    expByteQ.push_back(memByte(24'h000051));
    for (int i = 0; i < 3; i++) expAddrQ.push_back(24'h000050 + 24'(i));
    applyStimulus(8'h03, 1'b1, 24'h000050, 2);
    checkFetches("post_reset");
    checkOutput("post_reset_underrun", 32'(underrun), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/flash_spi_responder.md
# flash_spi_responder

SPI-flash slave emulator: it answers the same single-lane mode-0 read protocol that the cartridge loader's flash master issues. It decodes the command and 24-bit address, fetches bytes from a backing byte-memory port, and shifts them out on MISO. It lets a host MCU, or a simulation bench, stand in for the physical configuration flash when feeding cartridge images to the loader.

## Interface
- CLK_PER_HALF_SCLK, 8: minimum system clocks per SCLK half-period that the block is guaranteed to handle; must be ≥ 8.
- clock  in  1  system clock; all logic runs on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- spi_cs  in  1  chip select, active low; asynchronous to clock.
- spi_sclk  in  1  SPI clock (mode 0, idle low); asynchronous to clock.
- spi_mosi  in  1  command/address bits from master, MSB first.
- spi_miso  out  1  data bits to master, MSB first.
- mem_req  out  1  byte-fetch request; held until mem_ack.
- mem_addr  out  24  byte address; stable while mem_req is high.
- mem_ack  in  1  one-cycle acknowledge; mem_rdata is valid in this cycle.
- mem_rdata  in  8  fetched byte.
- busy  out  1  high while the synchronized CS is asserted.
- last_cmd  out  8  most recent complete command byte.
- underrun  out  1  sticky; set when a byte is needed before its fetch completed.

## Operation
- Input sync: 2-FF synchronizers on cs, sclk, and mosi, followed by a registered previous-value stage for edge detection.
  - rise = sclk_s & !sclk_p; fall = !sclk_s & sclk_p.
- MOSI is sampled on rise. MISO is updated on fall, and also on the CS-fall edge for a consistent idle level.
- FSM states: IDLE, CMD, ADDR, DATA, IGNORE.
  - Any state → IDLE when synchronized CS goes high (abort).
  - IDLE → CMD on synchronized CS falling; bit counter cleared.
  - CMD: shift 8 bits. On the 8th rise, last_cmd updates, then:
    - 0x03 → ADDR.
    - 0xAB (wake) → IGNORE.
    - any other value → IGNORE.
  - ADDR: shift 24 bits into addr_reg. On the 24th rise, issue a fetch for addr_reg and go to DATA.
  - DATA: on each byte boundary fall (the first fall after the 8th bit's rise; for the first byte, the first fall after ADDR completes):
    - Load the shift register from the fetch buffer and drive its MSB.
    - Increment addr_reg by 1, wrapping 24 bits (0xFFFFFF → 0x000000).
    - Issue the next fetch immediately.
  - DATA, other falls: shift left and drive the next bit.
  - IGNORE: MISO held 1 until CS high.
- Fetch buffer: one byte plus a valid flag.
  - Set on mem_ack; cleared when the byte is loaded into the shift register.
  - If a byte boundary arrives with the buffer invalid: load 0xFF, set underrun, and keep the fetch outstanding. Its data lands in the buffer and is used for the following byte; the address sequence is not skipped.
- Abort with a fetch outstanding: keep mem_req high until mem_ack, then discard the data. A new CMD phase may start meanwhile, but no new fetch is issued until the old one is acked.
- MISO is 1 in IDLE, CMD, ADDR, and IGNORE.

## Timing
- Reset values:
  - spi_miso=1, mem_req=0, mem_addr=0, busy=0, last_cmd=0x00, underrun=0.
  - FSM=IDLE; synchronizer flops reset to cs=1, sclk=0, mosi=0.
- Pin-to-event latency is 3 clocks (2 sync + 1 edge). spi_miso changes in the clock after the fall is detected, i.e. 4 clocks after the physical SCLK fall.
- mem_req rises the cycle after the 24th address rise is detected. mem_addr is registered in the same cycle.
- A requester must ack within CLK_PER_HALF_SCLK−4 clocks of mem_req to avoid underrun on the first byte. Later bytes get 8 SCLK periods.
- mem_req drops in the cycle after mem_ack. A new req may assert the cycle after that at the earliest, so there is at most one outstanding fetch.
- busy follows the synchronized CS: asserts/deasserts 2 clocks after the pin.
- CS rise coinciding with an SCLK edge: the CS abort wins and the edge is ignored.
- Reset mid-transfer: all state clears immediately; an outstanding handshake is dropped.

## Test plan
- Read: cmd 0x03, addr 0x100000, memory holds byte i = i[7:0], 4 bytes clocked at clock/16 → MISO 0x00,0x01,0x02,0x03; mem_addr sequence 0x100000..0x100004; underrun=0; last_cmd=0x03.
- Wrap: cmd 0x03, addr 0xFFFFFF, 2 bytes read → mem_addr 0xFFFFFF then 0x000000; MISO = mem[0xFFFFFF], mem[0x000000].
- Underrun: ack delayed 40 clocks on the first fetch → first byte reads 0xFF, underrun=1, second byte = mem[addr]; underrun stays 1 across a new CS cycle until reset.
- Non-read command: 0xAB then 16 more SCLKs → MISO constantly 1, no mem_req, last_cmd=0xAB.
- Abort: CS raised after 12 address bits, then a full 0x03 read to 0x000010 → first transaction issues no fetch; second returns mem[0x10] correctly.
- Reset during DATA with mem_req high → next cycle mem_req=0, spi_miso=1, busy=0; a subsequent read works normally.
